// File: rtl/tff_updown_counter.sv
// tff_updown_counter: modulo-N up/down counter built from T-type bits; define TFF_CNT_SATURATE_EN to saturate instead of wrap.
module tff_updown_counter #(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Enable,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] Data,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             TC,
  output logic             Wrap
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);
  logic [WIDTH-1:0] q_q, q_d, t_d, up_c, dn_c, m, load_val, cnt_t, wrap_t;
  logic             wrap_q, wrap_d;
  // Bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    up_c = '0;
    dn_c = '0;
    m    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m       = WIDTH'((64'd1 << i) - 64'd1);
      up_c[i] = &(q_q | ~m);
      dn_c[i] = ~|(q_q & m);
    end
  end
  assign TC       = Enable & (Up ? (q_q == MAX) : (q_q == '0));
  assign load_val = (Data > MAX) ? MAX : Data;
  assign cnt_t    = Up ? up_c : dn_c;
`ifdef TFF_CNT_SATURATE_EN
  assign wrap_t = '0;
  assign wrap_d = 1'b0;
`else
  assign wrap_t = q_q ^ (Up ? '0 : MAX);
  assign wrap_d = ~Load & TC;
`endif
  assign t_d = Load ? (q_q ^ load_val) : Enable ? (TC ? wrap_t : cnt_t) : '0;
  assign q_d = q_q ^ t_d;
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end
  assign Q    = q_q;
  assign Qbar = ~q_q;
  assign Wrap = wrap_q;
endmodule

// File: tb/tb_tff_updown_counter.sv
// tb_tff_updown_counter: directed and randomized checks of a WIDTH=4, MODULUS=10 counter against a behavioural model.
module tb_tff_updown_counter;
  localparam int W = 4;
  localparam int M = 10;
  logic         clk = 1'b0, clr_n = 1'b0, en = 1'b0, up = 1'b1, ld = 1'b0;
  logic [W-1:0] data = '0;
  logic [W-1:0] q, qbar;
  logic         tc, wrap;
  int           checks = 0, failures = 0;
  int           mq = 0, mw = 0;

  tff_updown_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .Clock(clk), .Clear(clr_n), .Enable(en), .Up(up), .Load(ld), .Data(data),
    .Q(q), .Qbar(qbar), .TC(tc), .Wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_tc();
    return int'(en && ((up && mq == M - 1) || (!up && mq == 0)));
  endfunction

  task automatic chk_out(input string tag);
    chk({tag, ".q"}, 32'(q), mq);
    chk({tag, ".qbar"}, 32'(qbar), 32'((~mq) & 15));
    chk({tag, ".wrap"}, 32'(wrap), mw);
  endtask

  task automatic cyc(input logic e, input logic u, input logic l, input int d);
    en = e; up = u; ld = l; data = d[W-1:0];
    #1 chk("tc", 32'(tc), exp_tc());
    @(posedge clk);
    if (!clr_n) begin
      mq = 0; mw = 0;
    end else if (l) begin
      mq = (d > M - 1) ? M - 1 : d; mw = 0;
    end else if (e) begin
      mw = 0;
`ifdef TFF_CNT_SATURATE_EN
      if (u) mq = (mq == M - 1) ? mq : mq + 1;
      else   mq = (mq == 0) ? mq : mq - 1;
`else
      if (u) begin if (mq == M - 1) begin mq = 0; mw = 1; end else mq++; end
      else   begin if (mq == 0) begin mq = M - 1; mw = 1; end else mq--; end
`endif
    end else mw = 0;
    #1 chk_out("cyc");
  endtask

  initial begin
    #2 chk_out("reset");
    @(negedge clk); clr_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b0, 1'b1, 1'b1, 7);
    // Asynchronous clear between edges.
    en = 1'b1; up = 1'b0;
    #2 clr_n = 1'b0; mq = 0; mw = 0;
    #1 chk_out("async_clr");
    chk("clr_tc", 32'(tc), 1);
    cyc(1'b1, 1'b1, 1'b1, 5);
    clr_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b1, 1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b1, 13);
    cyc(1'b1, 1'b0, 1'b1, 4);
    cyc(1'b0, 1'b1, 1'b1, 3);
    for (int i = 0; i < 6; i++) cyc(i[0] == 1'b0, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b1, 8);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        clr_n = 1'b0; mq = 0; mw = 0;
        #1 chk_out("rnd_clr");
        cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)));
        clr_n = 1'b1;
      end
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
